// File: rtl/dmem_responder.sv
// Word-organised data-memory responder with a programmable wait-state count.
// One request is accepted at a time; ack, err, busy and rdata come straight from flops.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ack,
  output logic        o_err,
  output logic        o_busy
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  // state | meaning
  // IDLE  | waiting for req; WAIT | counting wait states; RESP | ack cycle
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_ack;
  logic          r_err;
  logic          r_busy;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [1:0]    w_next_state;
  logic          w_capture;
  logic          w_enter_resp;
  logic          w_we_eff;
  logic [31:0]   w_addr_eff;
  logic [31:0]   w_wdata_eff;
  logic [29:0]   w_idx;
  logic [AW-1:0] w_mem_idx;
  logic          w_err;
  logic          w_mem_we;

  // With zero wait states RESP is entered on the capture edge itself, so the
  // access must be decoded from the live inputs while still in IDLE.
  always_comb begin
    w_capture   = (r_state == S_IDLE) && i_req;
    w_we_eff    = (r_state == S_IDLE) ? i_we    : r_we;
    w_addr_eff  = (r_state == S_IDLE) ? i_addr  : r_addr;
    w_wdata_eff = (r_state == S_IDLE) ? i_wdata : r_wdata;
    w_idx       = w_addr_eff[31:2];
    w_mem_idx   = w_idx[AW-1:0];
    w_err       = (w_addr_eff[1:0] != 2'b00) || (w_idx >= 30'(DEPTH_WORDS));
    w_enter_resp = (w_capture && (WAIT_CYCLES == 0)) ||
                   ((r_state == S_WAIT) && (r_cnt == '0));
    w_mem_we    = w_enter_resp && w_we_eff && !w_err && i_rst_n;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_req) w_next_state = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) w_next_state = S_RESP;
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_capture) begin
        r_we    <= i_we;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_cnt   <= CNT_LOAD;
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      r_ack  <= w_enter_resp;
      r_err  <= w_enter_resp && w_err;
      r_busy <= (w_next_state != S_IDLE);
      if (w_enter_resp && (w_err || !w_we_eff)) begin
        r_rdata <= w_err ? 32'h0 : r_mem[w_mem_idx];
      end
    end
  end

  // RAM array is deliberately left without reset.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[w_mem_idx] <= w_wdata_eff;
  end

  assign o_rdata = r_rdata;
  assign o_ack   = r_ack;
  assign o_err   = r_err;
  assign o_busy  = r_busy;

endmodule
